// File: rtl/nba_merge_arbiter.sv
// Round-robin write arbiter that merges lane-masked writes into a shadow buffer and
// commits them to q at the end of an epoch. Optional sticky conflict flag: NBA_MERGE_CONFLICT_EN.
module nba_merge_arbiter #(
  parameter int NREQ = 2,
  parameter int LANE_W = 4,
  parameter int NLANES = 2,
  parameter logic [LANE_W*NLANES-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_whole,
  input  logic [NREQ*NLANES-1:0]   req_mask,
  input  logic [NREQ*LANE_W*NLANES-1:0] req_data,
  input  logic                     commit,
  output logic [LANE_W*NLANES-1:0] q,
  output logic [NLANES-1:0]        pending,
  output logic                     busy,
  output logic                     commit_done,
  output logic                     conflict
);

  localparam int WIDTH = LANE_W * NLANES;
  localparam int RR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: a write transfers on a rising edge where req_valid[i] & req_ready[i];
  // req_ready is combinational, one-hot or zero, and never set without req_valid.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [RR_W-1:0]   rr;
  logic [RR_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic [WIDTH-1:0]  shadow;
  logic              sel_whole;
  logic [NLANES-1:0] sel_mask;
  logic [WIDTH-1:0]  sel_data;
  logic [NLANES-1:0] eff_mask;
  int                cand;

  // First valid requester at or above rr, wrapping.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    req_ready = '0;
    if (rst_n && state != S_FLUSH) begin
      for (int off = 0; off < NREQ; off++) begin
        cand = (int'(rr) + off) % NREQ;
        if (!gnt_any && req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = RR_W'(cand);
        end
      end
      if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_whole = req_whole[gnt_idx];
    sel_mask  = req_mask[int'(gnt_idx)*NLANES +: NLANES];
    sel_data  = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
    eff_mask  = sel_whole ? {NLANES{1'b1}} : sel_mask;
  end

  // Commit outranks ACCUM entry; FLUSH always lasts exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (commit) state_next = S_FLUSH;
        else if (gnt_any && (eff_mask != '0)) state_next = S_ACCUM;
      end
      S_ACCUM: if (commit) state_next = S_FLUSH;
      S_FLUSH: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr          <= '0;
      shadow      <= '0;
      pending     <= '0;
      q           <= RESET_VAL;
      commit_done <= 1'b0;
    end else begin
      state       <= state_next;
      commit_done <= (state == S_FLUSH);
      if (state == S_FLUSH) begin
        for (int k = 0; k < NLANES; k++) begin
          if (pending[k]) q[k*LANE_W +: LANE_W] <= shadow[k*LANE_W +: LANE_W];
        end
        pending <= '0;
      end else if (gnt_any) begin
        for (int k = 0; k < NLANES; k++) begin
          if (eff_mask[k]) shadow[k*LANE_W +: LANE_W] <= sel_data[k*LANE_W +: LANE_W];
        end
        pending <= pending | eff_mask;
        rr      <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  assign busy = (state != S_IDLE);

`ifdef NBA_MERGE_CONFLICT_EN
  logic saw_whole, saw_partial, conflict_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      saw_whole   <= 1'b0;
      saw_partial <= 1'b0;
      conflict_r  <= 1'b0;
    end else begin
      conflict_r <= conflict_r | (saw_whole & saw_partial);
      if (state == S_FLUSH) begin
        saw_whole   <= 1'b0;
        saw_partial <= 1'b0;
      end else if (gnt_any) begin
        if (sel_whole) saw_whole <= 1'b1;
        if (!sel_whole && (sel_mask != '0)) saw_partial <= 1'b1;
      end
    end
  end

  assign conflict = conflict_r;
`else
  assign conflict = 1'b0;
`endif

endmodule
